seq_shift_unit: RTL and testbench

- Multi-cycle, parametrised successor to the 1-bit ALU shift-left cell.
- Shifts a WIDTH-bit operand by a runtime amount, one bit position per clock.
- Supports logical left, logical right, arithmetic right and rotate-left.
- Sits beside the ripple ALU slices and uses a start/busy/done handshake, so a controller FSM can issue shift ops.

---
 rtl/seq_shift_unit.sv | 119 +++++++++++
 tb/tb_seq_shift_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROL by a runtime amount, one bit per clock,
// behind a start/busy/done handshake for a controller FSM.
module seq_shift_unit #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         mode,
    output logic [WIDTH-1:0]   out,
    output logic               cout,
    output logic               busy,
    output logic               done,
    output logic [1:0]         dbg_state
);

    // Handshake: start is sampled only in IDLE; busy is high in SHIFT and DONE;
    // done is a one-cycle pulse during which out/cout hold the final result.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] M_SLL = 2'b00;
    localparam logic [1:0] M_SRL = 2'b01;
    localparam logic [1:0] M_SRA = 2'b10;
    localparam logic [1:0] M_ROL = 2'b11;

    localparam logic [SHAMT_W-1:0] WIDTH_C = SHAMT_W'(WIDTH);

    state_t             state, state_nx;
    logic [SHAMT_W-1:0] count, count_nx;
    logic [SHAMT_W-1:0] n_eff;
    logic [1:0]         mode_r, mode_nx;
    logic [WIDTH-1:0]   out_nx;
    logic               cout_nx;

    // Linear shifts saturate at WIDTH; rotates keep the raw amount and wrap.
    always_comb begin
        n_eff = shamt;
        if (mode != M_ROL && shamt > WIDTH_C) begin
            n_eff = WIDTH_C;
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        mode_nx  = mode_r;
        out_nx   = out;
        cout_nx  = cout;
        case (state)
            S_IDLE: begin
                if (start) begin
                    out_nx   = A;
                    cout_nx  = 1'b0;
                    count_nx = n_eff;
                    mode_nx  = mode;
                    state_nx = (n_eff == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                case (mode_r)
                    M_SLL: begin
                        cout_nx = out[WIDTH-1];
                        out_nx  = {out[WIDTH-2:0], 1'b0};
                    end
                    M_SRL: begin
                        cout_nx = out[0];
                        out_nx  = {1'b0, out[WIDTH-1:1]};
                    end
                    M_SRA: begin
                        cout_nx = out[0];
                        out_nx  = {out[WIDTH-1], out[WIDTH-1:1]};
                    end
                    default: begin
                        cout_nx = out[WIDTH-1];
                        out_nx  = {out[WIDTH-2:0], out[WIDTH-1]};
                    end
                endcase
                count_nx = count - 1'b1;
                if (count == SHAMT_W'(1)) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            count  <= '0;
            mode_r <= M_SLL;
            out    <= '0;
            cout   <= 1'b0;
        end else begin
            state  <= state_nx;
            count  <= count_nx;
            mode_r <= mode_nx;
            out    <= out_nx;
            cout   <= cout_nx;
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: each scenario task drives one operation
// and compares result, carry-out and done latency against hand-computed values.
module tb_seq_shift_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] A;
    logic [3:0] shamt;
    logic [1:0] mode;
    logic [7:0] out;
    logic       cout;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    seq_shift_unit #(.WIDTH(8), .SHAMT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .shamt(shamt),
        .mode(mode), .out(out), .cout(cout), .busy(busy), .done(done),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive start just after edge k; it is accepted at edge k+1. cyc counts
    // edges from k until done is seen, so a shift of n gives cyc = 1 + n.
    task automatic run_op(input logic [7:0] a, input logic [3:0] s, input logic [1:0] m,
                          output int cyc, output logic [7:0] r, output logic c,
                          output logic b1);
        @(posedge clk); #1;
        start = 1'b1; A = a; shamt = s; mode = m;
        @(posedge clk); #1;
        start = 1'b0;
        b1  = busy;
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        r = out;
        c = cout;
    endtask

    task automatic test_reset;
        #2;
        n_checks++; if (out !== 8'h00) $display("FAIL reset_out got %h exp 00", out); else n_pass++;
        n_checks++; if (cout !== 1'b0) $display("FAIL reset_cout got %b exp 0", cout); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_sll;
        int cyc; logic [7:0] r; logic c, b1;
        run_op(8'b1011_0011, 4'd3, 2'b00, cyc, r, c, b1);
        n_checks++; if (b1 !== 1'b1) $display("FAIL sll_busy got %b exp 1", b1); else n_pass++;
        n_checks++; if (cyc !== 4) $display("FAIL sll_latency got %0d exp 4", cyc); else n_pass++;
        n_checks++; if (r !== 8'b1001_1000) $display("FAIL sll_out got %b exp 10011000", r); else n_pass++;
        n_checks++; if (c !== 1'b1) $display("FAIL sll_cout got %b exp 1", c); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) $display("FAIL sll_done_pulse got %b exp 0", done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL sll_busy_end got %b exp 0", busy); else n_pass++;
        n_checks++; if (out !== 8'b1001_1000) $display("FAIL sll_hold got %b exp 10011000", out); else n_pass++;
    endtask

    task automatic test_sra;
        int cyc; logic [7:0] r; logic c, b1;
        run_op(8'b1000_0100, 4'd2, 2'b10, cyc, r, c, b1);
        n_checks++; if (cyc !== 3) $display("FAIL sra_latency got %0d exp 3", cyc); else n_pass++;
        n_checks++; if (r !== 8'b1110_0001) $display("FAIL sra_out got %b exp 11100001", r); else n_pass++;
        n_checks++; if (c !== 1'b0) $display("FAIL sra_cout got %b exp 0", c); else n_pass++;
    endtask

    task automatic test_srl_clamp;
        int cyc;
        @(posedge clk); #1;
        start = 1'b1; A = 8'b0000_0001; shamt = 4'd12; mode = 2'b01;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (cout !== 1'b1) $display("FAIL srl_first_cout got %b exp 1", cout); else n_pass++;
        cyc = 2;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++; if (cyc !== 9) $display("FAIL srl_latency got %0d exp 9", cyc); else n_pass++;
        n_checks++; if (out !== 8'h00) $display("FAIL srl_out got %h exp 00", out); else n_pass++;
        n_checks++; if (cout !== 1'b0) $display("FAIL srl_cout got %b exp 0", cout); else n_pass++;
    endtask

    task automatic test_rol;
        int cyc; logic [7:0] r; logic c, b1;
        run_op(8'b1000_0001, 4'd1, 2'b11, cyc, r, c, b1);
        n_checks++; if (cyc !== 2) $display("FAIL rol1_latency got %0d exp 2", cyc); else n_pass++;
        n_checks++; if (r !== 8'b0000_0011) $display("FAIL rol1_out got %b exp 00000011", r); else n_pass++;
        n_checks++; if (c !== 1'b1) $display("FAIL rol1_cout got %b exp 1", c); else n_pass++;
        run_op(8'b1000_0001, 4'd0, 2'b11, cyc, r, c, b1);
        n_checks++; if (cyc !== 1) $display("FAIL rol0_latency got %0d exp 1", cyc); else n_pass++;
        n_checks++; if (r !== 8'b1000_0001) $display("FAIL rol0_out got %b exp 10000001", r); else n_pass++;
        n_checks++; if (c !== 1'b0) $display("FAIL rol0_cout got %b exp 0", c); else n_pass++;
        // Rotate amounts above WIDTH are not clamped: 9 steps equals one full turn plus one.
        run_op(8'b1000_0001, 4'd9, 2'b11, cyc, r, c, b1);
        n_checks++; if (cyc !== 10) $display("FAIL rol9_latency got %0d exp 10", cyc); else n_pass++;
        n_checks++; if (r !== 8'b0000_0011) $display("FAIL rol9_out got %b exp 00000011", r); else n_pass++;
        n_checks++; if (c !== 1'b1) $display("FAIL rol9_cout got %b exp 1", c); else n_pass++;
    endtask

    task automatic test_busy_ignore;
        int cyc;
        @(posedge clk); #1;
        start = 1'b1; A = 8'h01; shamt = 4'd4; mode = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; A = 8'hFF; shamt = 4'd1; mode = 2'b01;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 3;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++; if (cyc !== 5) $display("FAIL ignore_latency got %0d exp 5", cyc); else n_pass++;
        n_checks++; if (out !== 8'h10) $display("FAIL ignore_out got %h exp 10", out); else n_pass++;
        n_checks++; if (cout !== 1'b0) $display("FAIL ignore_cout got %b exp 0", cout); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL ignore_idle got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1;
        start = 1'b1; A = 8'h55; shamt = 4'd0; mode = 2'b00;
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b1) $display("FAIL b2b_first_done got %b exp 1", done); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL b2b_gap_busy got %b exp 0", busy); else n_pass++;
        A = 8'h3C;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (done !== 1'b1) $display("FAIL b2b_second_done got %b exp 1", done); else n_pass++;
        n_checks++; if (out !== 8'h3C) $display("FAIL b2b_second_out got %h exp 3c", out); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int cyc; logic [7:0] r; logic c, b1;
        @(posedge clk); #1;
        start = 1'b1; A = 8'hFF; shamt = 4'd8; mode = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out !== 8'h00) $display("FAIL midrst_out got %h exp 00", out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL midrst_done got %b exp 0", done); else n_pass++;
        n_checks++; if (cout !== 1'b0) $display("FAIL midrst_cout got %b exp 0", cout); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h80, 4'd8, 2'b10, cyc, r, c, b1);
        n_checks++; if (cyc !== 9) $display("FAIL postrst_latency got %0d exp 9", cyc); else n_pass++;
        n_checks++; if (r !== 8'hFF) $display("FAIL postrst_out got %h exp ff", r); else n_pass++;
        n_checks++; if (c !== 1'b1) $display("FAIL postrst_cout got %b exp 1", c); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        A     = 8'h00;
        shamt = 4'd0;
        mode  = 2'b00;
        test_reset;
        test_sll;
        test_sra;
        test_srl_clamp;
        test_rol;
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
